// File: rtl/cam_ctrl_16.sv
// cam_ctrl_16: lookup/insert controller for a 16-entry CAM (optional stats via CAM_CTRL_STATS_EN)
module cam_ctrl_16 #(
  parameter int DATA_SIZE = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_SIZE-1:0] req_key,
  input  logic                 req_insert,
  input  logic                 inv_all,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [3:0]           rsp_idx,
  output logic [DATA_SIZE-1:0] rsp_data,
  output logic [15:0]          cam_we,
  output logic [3:0]           cam_addr,
  output logic [DATA_SIZE-1:0] cam_wdata,
  output logic [DATA_SIZE-1:0] cam_rdata0,
  input  logic [15:0]          cam_hit0,
  input  logic [DATA_SIZE-1:0] cam_data,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses
);
  typedef enum logic [1:0] {IDLE, SEARCH, WRITE, RESP} state_t;
  state_t state, state_n;
  logic [15:0] valid, mhit;
  logic [3:0] rr_ptr, hit_idx, free_idx;
  logic [DATA_SIZE-1:0] key_q;
  logic ins_q;
  assign mhit       = cam_hit0 & valid;
  assign req_ready  = state == IDLE;
  assign rsp_valid  = state == RESP;
  assign cam_we     = (state == WRITE) ? 16'd1 << rsp_idx : 16'd0;
  assign cam_addr   = rsp_idx;
  assign rsp_data   = cam_data;
  assign cam_wdata  = key_q;
  assign cam_rdata0 = key_q;
  // lowest matching entry and lowest free entry
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mhit[i]) hit_idx = 4'(i);
      if (!valid[i]) free_idx = 4'(i);
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? SEARCH : IDLE;
      SEARCH:  state_n = (|mhit || !ins_q) ? RESP : WRITE;
      WRITE:   state_n = RESP;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // request capture, search result, victim choice and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      ins_q   <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_idx <= '0;
      rr_ptr  <= '0;
      valid   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        key_q <= req_key;
        ins_q <= req_insert;
      end
      if (state == SEARCH) begin
        rsp_hit <= |mhit;
        rsp_idx <= |mhit ? hit_idx : !ins_q ? 4'd0 : &valid ? rr_ptr : free_idx;
        if (!(|mhit) && ins_q && &valid) rr_ptr <= rr_ptr + 4'd1;
      end
      valid <= inv_all ? 16'd0 : (state == WRITE) ? valid | (16'd1 << rsp_idx) : valid;
    end
  end
`ifdef CAM_CTRL_STATS_EN
  // saturating hit/miss counters, one count per search
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == SEARCH) begin
      if (|mhit) stat_hits <= stat_hits + 16'(stat_hits != 16'hFFFF);
      else stat_misses <= stat_misses + 16'(stat_misses != 16'hFFFF);
    end
  end
`else
  assign stat_hits   = 16'h0;
  assign stat_misses = 16'h0;
`endif
endmodule

// File: tb/tb_cam_ctrl_16.sv
// tb_cam_ctrl_16: randomized self-checking bench against a CAM behavioural model
module tb_cam_ctrl_16;
  localparam int DS = 19;
  logic clk, rst, req_valid, req_ready, req_insert, inv_all, rsp_valid, rsp_ready, rsp_hit;
  logic [DS-1:0] req_key, rsp_data, cam_wdata, cam_rdata0, cam_data;
  logic [3:0] rsp_idx, cam_addr;
  logic [15:0] cam_we, cam_hit0, stat_hits, stat_misses, last_raw;
  logic [DS-1:0] mem [16];
  logic [DS-1:0] m_key [16];
  bit m_val [16];
  int m_rr, m_hits, m_miss, tests, fails;

  cam_ctrl_16 #(.DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_insert(req_insert), .inv_all(inv_all), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_data(rsp_data), .cam_we(cam_we),
    .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_rdata0(cam_rdata0), .cam_hit0(cam_hit0),
    .cam_data(cam_data), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    for (int i = 0; i < 16; i++) if (cam_we[i]) mem[i] <= cam_wdata;

  always_comb begin
    for (int i = 0; i < 16; i++) cam_hit0[i] = (mem[i] == cam_rdata0);
    cam_data = mem[cam_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef CAM_CTRL_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_miss);
`else
    chk("stat_hits", stat_hits, 0);
    chk("stat_misses", stat_misses, 0);
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_val[i] = 0;
  endtask

  task automatic do_inv();
    @(negedge clk); inv_all = 1;
    @(negedge clk); inv_all = 0;
    model_clear();
  endtask

  task automatic req(input logic [DS-1:0] key, input bit ins, input int hold);
    bit ehit, found;
    int eidx, lat;
    logic [15:0] ewe, we_seen;
    ehit = 0; eidx = 0; ewe = 0; found = 0;
    for (int i = 0; i < 16; i++)
      if (!ehit && m_val[i] && m_key[i] == key) begin ehit = 1; eidx = i; end
    if (!ehit && ins) begin
      for (int i = 0; i < 16; i++)
        if (!found && !m_val[i]) begin found = 1; eidx = i; end
      if (!found) begin eidx = m_rr; m_rr = (m_rr + 1) % 16; end
      m_val[eidx] = 1;
      m_key[eidx] = key;
      ewe = 16'd1 << eidx;
    end
    if (ehit) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
    else m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
    @(negedge clk);
    req_valid = 1; req_key = key; req_insert = ins;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    last_raw = cam_hit0;
    lat = 1;
    we_seen = cam_we;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (cam_we != 0) we_seen = cam_we;
    end
    chk("latency", lat, (!ehit && ins) ? 3 : 2);
    chk("cam_we", we_seen, ewe);
    chk("rsp_hit", rsp_hit, ehit);
    chk("rsp_idx", rsp_idx, eidx);
    if (ehit || ins) chk("rsp_data", rsp_data, key);
    chk_stats();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_idx", rsp_idx, eidx);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 0;
    chk("back_idle", req_ready, 1);
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    tests = 0; fails = 0; m_rr = 0; m_hits = 0; m_miss = 0;
    model_clear();
    rst = 1; req_valid = 0; req_key = '0; req_insert = 0; inv_all = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cam_we", cam_we, 0);
    chk("rst_rsp_idx", rsp_idx, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk_stats();
    req(19'h12345, 1, 0);
    req(19'h12345, 0, 0);
    do_inv();
    req(19'h12345, 0, 0);
    chk("raw_hit_masked", last_raw[0], 1);
    for (int i = 0; i < 16; i++) req(19'h100 + 19'(i), 1, 0);
    req(19'h200, 1, 0);
    req(19'h201, 1, 0);
    req(19'h200, 0, 0);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) do_inv();
      req(19'($urandom_range(1, 40)), bit'($urandom_range(0, 1)), 0);
    end
    req(19'h12345, 1, 0);
    req(19'h12345, 0, 5);
    @(negedge clk);
    req_valid = 1; req_key = 19'h777; req_insert = 1;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    @(posedge clk); @(negedge clk);
    chk("write_active", cam_we != 0, 1);
    rst = 1;
    #1;
    chk("rst_we_drop", cam_we, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(negedge clk); rst = 0;
    model_clear();
    m_rr = 0; m_hits = 0; m_miss = 0;
    chk_stats();
    req(19'h12345, 0, 0);
    req(19'h777, 0, 0);
    req(19'h777, 1, 0);
    req(19'h777, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
